// File: rtl/grey_seq_pkg.sv
// Shared types, command codes and Johnson-code helpers for the grey_seq
// sequencer: state encoding, 5-bit decade Johnson digit constants and
// conversions between BCD nibbles and Johnson digits.
package grey_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;
  localparam logic [1:0] CMD_LOAD  = 2'd3;

  localparam logic [4:0] DIG0 = 5'b00000;
  localparam logic [4:0] DIG1 = 5'b00001;
  localparam logic [4:0] DIG2 = 5'b00011;
  localparam logic [4:0] DIG3 = 5'b00111;
  localparam logic [4:0] DIG4 = 5'b01111;
  localparam logic [4:0] DIG5 = 5'b11111;
  localparam logic [4:0] DIG6 = 5'b11110;
  localparam logic [4:0] DIG7 = 5'b11100;
  localparam logic [4:0] DIG8 = 5'b11000;
  localparam logic [4:0] DIG9 = 5'b10000;

  // Nibbles above 9 map to the top digit so a stray value can never
  // produce an illegal Johnson pattern.
  function automatic logic [4:0] bcd_to_johnson(input logic [3:0] bcd);
    logic [4:0] j;
    case (bcd)
      4'd0:    j = DIG0;
      4'd1:    j = DIG1;
      4'd2:    j = DIG2;
      4'd3:    j = DIG3;
      4'd4:    j = DIG4;
      4'd5:    j = DIG5;
      4'd6:    j = DIG6;
      4'd7:    j = DIG7;
      4'd8:    j = DIG8;
      default: j = DIG9;
    endcase
    return j;
  endfunction

  // Illegal Johnson patterns decode as 0; the digit registers never hold one.
  function automatic logic [3:0] johnson_to_bcd(input logic [4:0] j);
    logic [3:0] b;
    case (j)
      DIG1:    b = 4'd1;
      DIG2:    b = 4'd2;
      DIG3:    b = 4'd3;
      DIG4:    b = 4'd4;
      DIG5:    b = 4'd5;
      DIG6:    b = 4'd6;
      DIG7:    b = 4'd7;
      DIG8:    b = 4'd8;
      DIG9:    b = 4'd9;
      default: b = 4'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/grey_seq_digit.sv
// One decade Johnson-code digit register with synchronous clear, parallel
// load and ripple-free increment. Carry-out is combinational so all three
// digits of the chain update on the same edge.
module grey_seq_digit
  import grey_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [4:0] i_load_val,
  input  logic       i_inc,
  input  logic       i_cin,
  output logic       o_cout,
  output logic [4:0] o_q
);

  logic [4:0] q;
  logic       adv;

  // A digit only advances when the chain tick reaches it through the carries.
  assign adv    = i_inc && i_cin;
  assign o_cout = adv && (q == DIG9);
  assign o_q    = q;

  // Digit register: clear beats load beats increment; 9 wraps to 0 naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q <= DIG0;
    end else if (i_clr) begin
      q <= DIG0;
    end else if (i_load) begin
      q <= i_load_val;
    end else if (adv) begin
      q <= {q[3:0], ~q[4]};
    end
  end

endmodule

// File: rtl/grey_seq_ctrl.sv
// Run/pause/clear/load sequencer for a 3-digit decade Johnson counter.
// Owns the prescaler, the preset register and three grey_seq_digit
// instances; commands arrive over a valid/ready port.
// Build option: define GREY_SEQ_AUTORELOAD_EN to reload the digits from the
// preset and keep running on terminal count (default: hold and go IDLE).
module grey_seq_ctrl
  import grey_seq_pkg::*;
#(
  parameter int unsigned pCOUNT = 1000,
  parameter int unsigned pCW    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd,
  output logic        o_cmd_ready,
  input  logic [11:0] i_load_bcd,
  input  logic [11:0] i_limit_bcd,
  output logic [4:0]  o_100,
  output logic [4:0]  o_010,
  output logic [4:0]  o_001,
  output logic        o_tick,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_state
);

  localparam logic [pCW-1:0] PRESC_LAST = pCW'(pCOUNT - 1);

  // Saturate a BCD nibble into the legal 0..9 range.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

  state_e         state_q, state_d;
  state_e         origin_q, origin_d;
  logic [1:0]     step_q, step_d;
  logic [pCW-1:0] presc_q, presc_d;
  logic [11:0]    preset_q, preset_d;
  logic           tick_q, done_q, err_q;

  logic           ready, accept;
  logic           is_start, is_stop, is_clear, is_load;
  logic           wrap, tick_ev, match, done_ev, adv, err_ev, reload;
  logic           load_act;
  logic [11:0]    cur_bcd;
  logic           ld_u, ld_t, ld_h;
  logic [4:0]     val_u, val_t, val_h;
  logic [4:0]     q_u, q_t, q_h;
  logic           cout_u, cout_t, cout_h_unused;

  // Control state, prescaler, preset and registered event pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      origin_q <= ST_IDLE;
      step_q   <= 2'd0;
      presc_q  <= '0;
      preset_q <= 12'h000;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      step_q   <= step_d;
      presc_q  <= presc_d;
      preset_q <= preset_d;
      tick_q   <= tick_ev;
      done_q   <= done_ev;
      err_q    <= err_ev;
    end
  end

  // Command decode, tick/terminal events and digit-chain controls.
  always_comb begin : ctrl_decode
    ready    = (state_q != ST_LOAD);
    accept   = i_cmd_valid && ready;
    is_start = accept && (i_cmd == CMD_START);
    is_stop  = accept && (i_cmd == CMD_STOP);
    is_clear = accept && (i_cmd == CMD_CLEAR);
    is_load  = accept && (i_cmd == CMD_LOAD);

    // A STOP or CLEAR landing on the wrap cycle swallows that tick entirely.
    wrap     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    tick_ev  = wrap && !is_stop && !is_clear;

    // Digits are always 0..9, so a limit nibble above 9 can never compare equal.
    cur_bcd  = {johnson_to_bcd(q_h), johnson_to_bcd(q_t), johnson_to_bcd(q_u)};
    match    = (cur_bcd == i_limit_bcd);
    done_ev  = tick_ev && match;
    adv      = tick_ev && !match;
    err_ev   = is_load && (state_q == ST_RUN);

`ifdef GREY_SEQ_AUTORELOAD_EN
    reload   = done_ev;
`else
    reload   = 1'b0;
`endif

    // LOAD writes units, tens, hundreds on successive cycles.
    load_act = (state_q == ST_LOAD);
    ld_u     = (load_act && (step_q == 2'd0)) || reload;
    ld_t     = (load_act && (step_q == 2'd1)) || reload;
    ld_h     = (load_act && (step_q == 2'd2)) || reload;
    val_u    = load_act ? bcd_to_johnson(bcd_clamp(i_load_bcd[3:0]))
                        : bcd_to_johnson(preset_q[3:0]);
    val_t    = load_act ? bcd_to_johnson(bcd_clamp(i_load_bcd[7:4]))
                        : bcd_to_johnson(preset_q[7:4]);
    val_h    = load_act ? bcd_to_johnson(bcd_clamp(i_load_bcd[11:8]))
                        : bcd_to_johnson(preset_q[11:8]);
  end

  // Next-state logic: command handling, prescaler stepping and LOAD sequencing.
  always_comb begin : next_state
    state_d  = state_q;
    origin_d = origin_q;
    step_d   = step_q;
    presc_d  = presc_q;
    preset_d = preset_q;
    if (is_clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_start) begin
            state_d = ST_RUN;
            presc_d = '0;
          end else if (is_load) begin
            state_d  = ST_LOAD;
            origin_d = ST_IDLE;
            step_d   = 2'd0;
          end
        end
        ST_RUN: begin
          if (is_stop) begin
            // The STOP cycle itself was spent running, so it still counts;
            // on the wrap cycle the count is parked so the swallowed tick
            // comes out on the first cycle after resuming.
            state_d = ST_PAUSE;
            presc_d = wrap ? presc_q : presc_q + 1'b1;
          end else begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            if (done_ev) begin
`ifdef GREY_SEQ_AUTORELOAD_EN
              state_d = ST_RUN;
`else
              state_d = ST_IDLE;
`endif
            end
          end
        end
        ST_PAUSE: begin
          if (is_start) begin
            state_d = ST_RUN;
          end else if (is_load) begin
            state_d  = ST_LOAD;
            origin_d = ST_PAUSE;
            step_d   = 2'd0;
          end
        end
        ST_LOAD: begin
          case (step_q)
            2'd0:    preset_d[3:0]  = bcd_clamp(i_load_bcd[3:0]);
            2'd1:    preset_d[7:4]  = bcd_clamp(i_load_bcd[7:4]);
            default: preset_d[11:8] = bcd_clamp(i_load_bcd[11:8]);
          endcase
          if (step_q == 2'd2) begin
            state_d = origin_q;
            step_d  = 2'd0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output drive: ready is a pure function of state, pulses come from registers.
  always_comb begin : out_drive
    o_cmd_ready = ready;
    o_state     = state_q;
    o_tick      = tick_q;
    o_done      = done_q;
    o_err       = err_q;
    o_001       = q_u;
    o_010       = q_t;
    o_100       = q_h;
  end

  grey_seq_digit u_dig_001 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (is_clear),
    .i_load     (ld_u),
    .i_load_val (val_u),
    .i_inc      (adv),
    .i_cin      (1'b1),
    .o_cout     (cout_u),
    .o_q        (q_u)
  );

  grey_seq_digit u_dig_010 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (is_clear),
    .i_load     (ld_t),
    .i_load_val (val_t),
    .i_inc      (adv),
    .i_cin      (cout_u),
    .o_cout     (cout_t),
    .o_q        (q_t)
  );

  // 999 simply wraps to 000; the top carry has no consumer.
  grey_seq_digit u_dig_100 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (is_clear),
    .i_load     (ld_h),
    .i_load_val (val_h),
    .i_inc      (adv),
    .i_cin      (cout_t),
    .o_cout     (cout_h_unused),
    .o_q        (q_h)
  );

endmodule

// File: tb/tb_grey_seq_ctrl.sv
// Directed self-checking bench for grey_seq_ctrl with a 4-cycle prescaler.
module tb_grey_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [11:0] load_bcd = 12'h000;
  logic [11:0] limit_bcd = 12'hFFF;
  logic        cmd_ready, tick, done, err;
  logic [4:0]  d100, d010, d001;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] J [10];

  always #5 clk = ~clk;

  grey_seq_ctrl #(.pCOUNT(4), .pCW(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .i_cmd       (cmd),
    .o_cmd_ready (cmd_ready),
    .i_load_bcd  (load_bcd),
    .i_limit_bcd (limit_bcd),
    .o_100       (d100),
    .o_010       (d010),
    .o_001       (d001),
    .o_tick      (tick),
    .o_done      (done),
    .o_err       (err),
    .o_state     (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({d100, d010, d001} !== 15'd0) begin n_fail++; $display("FAIL reset_digits got %h want 0", {d100, d010, d001}); end
    n_cmp++; if ({tick, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {tick, done, err}); end
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state_rel got %0d want 0", state); end
  endtask

  task automatic test_count();
    int k;
    limit_bcd = 12'hFFF;
    send(2'd0);
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL count_state got %0d want 1", state); end
    for (int c = 1; c <= 40; c++) begin
      step();
      k = c / 4;
      n_cmp++; if (tick !== ((c % 4) == 0)) begin n_fail++; $display("FAIL count_tick c=%0d got %b want %b", c, tick, (c % 4) == 0); end
      n_cmp++; if (d001 !== J[k % 10] || d010 !== J[k / 10] || d100 !== J[0]) begin
        n_fail++; $display("FAIL count_digits c=%0d got %b/%b/%b want %b/%b/%b", c, d100, d010, d001, J[0], J[k / 10], J[k % 10]);
      end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL count_done c=%0d got %b want 0", c, done); end
    end
    send(2'd2);
    n_cmp++; if (state !== 2'd0 || {d100, d010, d001} !== 15'd0) begin n_fail++; $display("FAIL count_clear got st=%0d dig=%h want st=0 dig=0", state, {d100, d010, d001}); end
  endtask

  task automatic test_clear_on_wrap();
    send(2'd0);
    repeat (3) step();
    send(2'd2);
    n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL wrapclr_tick got %b want 0", tick); end
    n_cmp++; if (d001 !== J[0] || state !== 2'd0) begin n_fail++; $display("FAIL wrapclr_state got st=%0d u=%b want st=0 u=%b", state, d001, J[0]); end
  endtask

  task automatic test_pause();
    send(2'd0);
    repeat (4) step();
    n_cmp++; if (tick !== 1'b1 || d001 !== J[1]) begin n_fail++; $display("FAIL pause_first got t=%b u=%b want t=1 u=%b", tick, d001, J[1]); end
    repeat (2) step();
    send(2'd1);
    n_cmp++; if (state !== 2'd2 || tick !== 1'b0) begin n_fail++; $display("FAIL pause_enter got st=%0d t=%b want st=2 t=0", state, tick); end
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++; if (tick !== 1'b0 || d001 !== J[1] || state !== 2'd2) begin
        n_fail++; $display("FAIL pause_hold c=%0d got t=%b u=%b st=%0d want t=0 u=%b st=2", c, tick, d001, state, J[1]);
      end
    end
    send(2'd0);
    n_cmp++; if (state !== 2'd1 || tick !== 1'b0) begin n_fail++; $display("FAIL pause_resume got st=%0d t=%b want st=1 t=0", state, tick); end
    step();
    n_cmp++; if (tick !== 1'b1 || d001 !== J[2]) begin n_fail++; $display("FAIL pause_tick got t=%b u=%b want t=1 u=%b", tick, d001, J[2]); end
    step();
    n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL pause_pulse got %b want 0", tick); end
    send(2'd2);
  endtask

  task automatic test_load();
    load_bcd = 12'h998;
    send(2'd3);
    n_cmp++; if (cmd_ready !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL load_enter got rdy=%b st=%0d want rdy=0 st=3", cmd_ready, state); end
    step();
    n_cmp++; if (cmd_ready !== 1'b0 || d001 !== J[8]) begin n_fail++; $display("FAIL load_units got rdy=%b u=%b want rdy=0 u=%b", cmd_ready, d001, J[8]); end
    step();
    n_cmp++; if (cmd_ready !== 1'b0 || d010 !== J[9]) begin n_fail++; $display("FAIL load_tens got rdy=%b t=%b want rdy=0 t=%b", cmd_ready, d010, J[9]); end
    step();
    n_cmp++; if (cmd_ready !== 1'b1 || state !== 2'd0 || d100 !== J[9]) begin
      n_fail++; $display("FAIL load_hund got rdy=%b st=%0d h=%b want rdy=1 st=0 h=%b", cmd_ready, state, d100, J[9]);
    end
    limit_bcd = 12'hFFF;
    send(2'd0);
    repeat (4) step();
    n_cmp++; if (tick !== 1'b1 || {d100, d010, d001} !== {J[9], J[9], J[9]}) begin n_fail++; $display("FAIL load_999 got t=%b dig=%b/%b/%b want t=1 999", tick, d100, d010, d001); end
    repeat (4) step();
    n_cmp++; if (tick !== 1'b1 || {d100, d010, d001} !== 15'd0) begin n_fail++; $display("FAIL load_wrap got t=%b dig=%b/%b/%b want t=1 000", tick, d100, d010, d001); end
    send(2'd2);
  endtask

  task automatic test_limit();
    limit_bcd = 12'h005;
    send(2'd0);
    for (int c = 1; c <= 24; c++) begin
      step();
      if ((c % 4) != 0) begin
        n_cmp++; if (tick !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL limit_idle c=%0d got t=%b d=%b want 0/0", c, tick, done); end
      end else if (c < 24) begin
        n_cmp++; if (tick !== 1'b1 || done !== 1'b0 || d001 !== J[c / 4]) begin
          n_fail++; $display("FAIL limit_tick c=%0d got t=%b d=%b u=%b want t=1 d=0 u=%b", c, tick, done, d001, J[c / 4]);
        end
      end else begin
        n_cmp++; if (tick !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL limit_done got t=%b d=%b want 1/1", tick, done); end
`ifdef GREY_SEQ_AUTORELOAD_EN
        n_cmp++; if ({d100, d010, d001} !== {J[9], J[9], J[8]} || state !== 2'd1) begin
          n_fail++; $display("FAIL limit_reload got %b/%b/%b st=%0d want 998 st=1", d100, d010, d001, state);
        end
`else
        n_cmp++; if ({d100, d010, d001} !== {J[0], J[0], J[5]} || state !== 2'd0) begin
          n_fail++; $display("FAIL limit_hold got %b/%b/%b st=%0d want 005 st=0", d100, d010, d001, state);
        end
`endif
      end
    end
    step();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL limit_pulse got %b want 0", done); end
    send(2'd2);
  endtask

  task automatic test_err_clamp();
    limit_bcd = 12'hFFF;
    load_bcd = 12'h555;
    send(2'd0);
    send(2'd3);
    n_cmp++; if (err !== 1'b1 || state !== 2'd1 || d001 !== J[0]) begin
      n_fail++; $display("FAIL err_pulse got e=%b st=%0d u=%b want e=1 st=1 u=%b", err, state, d001, J[0]);
    end
    step();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err); end
    send(2'd2);
    load_bcd = 12'hC3C;
    send(2'd3);
    repeat (3) step();
    n_cmp++; if ({d100, d010, d001} !== {J[9], J[3], J[9]} || state !== 2'd0) begin
      n_fail++; $display("FAIL clamp_load got %b/%b/%b st=%0d want %b/%b/%b st=0", d100, d010, d001, state, J[9], J[3], J[9]);
    end
  endtask

  task automatic test_reset_mid_load();
    load_bcd = 12'h123;
    send(2'd3);
    step();
    n_cmp++; if (d001 !== J[3] || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL midload_pre got u=%b rdy=%b want u=%b rdy=0", d001, cmd_ready, J[3]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({d100, d010, d001} !== 15'd0 || {tick, done, err} !== 3'b000) begin
      n_fail++; $display("FAIL midload_async got dig=%h pulses=%b want 0/000", {d100, d010, d001}, {tick, done, err});
    end
    n_cmp++; if (state !== 2'd0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midload_state got st=%0d rdy=%b want 0/1", state, cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (state !== 2'd0 || cmd_ready !== 1'b1 || {d100, d010, d001} !== 15'd0) begin
      n_fail++; $display("FAIL midload_release got st=%0d rdy=%b dig=%h want 0/1/0", state, cmd_ready, {d100, d010, d001});
    end
  endtask

  initial begin
    J = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
          5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
    test_reset();
    test_count();
    test_clear_on_wrap();
    test_pause();
    test_load();
    test_limit();
    test_err_clamp();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/grey_seq_ctrl.md
Name: grey_seq_ctrl

Overview:
- Run/pause/clear/load sequencer for the 3-digit decade Johnson-code (grey_10-style) counter display chain.
- Owns the prescaler and the three 5-bit digit registers, and accepts commands over a valid/ready port.
- All digits update synchronously in one cycle; there are no derived clocks.
- Flags a programmable terminal count; sits between the host/command logic and the digit outputs.

Parameters:
- pCOUNT, 1000, prescaler period in i_clk cycles per count tick; legal range 2..65535.
- pCW, 16, prescaler counter width.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command strobe
- i_cmd  in  2  0=START, 1=STOP, 2=CLEAR, 3=LOAD
- o_cmd_ready  out  1  command accepted when valid&&ready
- i_load_bcd  in  12  preset value {hundreds,tens,units}; sampled per digit during LOAD
- i_limit_bcd  in  12  terminal count, compared live
- o_100  out  5  hundreds digit, Johnson code
- o_010  out  5  tens digit, Johnson code
- o_001  out  5  units digit, Johnson code
- o_tick  out  1  one-cycle count-advance pulse
- o_done  out  1  one-cycle terminal-count pulse
- o_err  out  1  one-cycle illegal-command pulse
- o_state  out  2  FSM state encoding

Behaviour:
- Reset is asynchronous, active-low; i_clk is the only clock.
- Reset values: state=IDLE, digits=00000, prescaler=0, preset=000, o_tick/o_done/o_err=0. o_cmd_ready=1 once reset is released.
- Johnson code, digit 0..9: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
  - Increment is {q[3:0], ~q[4]}; 9 wraps to 0 and carries.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LOAD=3.
- o_cmd_ready = (state != LOAD). A command is accepted only on the valid&&ready cycle.
- START:
  - IDLE->RUN with prescaler cleared.
  - PAUSE->RUN with prescaler value retained.
  - In RUN: no-op.
- STOP:
  - RUN->PAUSE; prescaler frozen.
  - In IDLE or PAUSE: no-op.
- CLEAR:
  - Any ready state -> IDLE. Digits=0 and prescaler=0 on the next edge.
  - The preset register is kept.
- LOAD from IDLE or PAUSE:
  - Enters LOAD for exactly 3 cycles: units, then tens, then hundreds. Each cycle writes one digit register and the matching preset field.
  - Then returns to the originating state.
  - A BCD nibble >9 is clamped to 9.
- LOAD in RUN: ignored; o_err=1 for one cycle.
- RUN counting:
  - Prescaler counts 0..pCOUNT-1.
  - On wrap, o_tick=1 for one cycle and a terminal check is made against the current count:
    - count != limit: digits advance by 1 in the same edge as o_tick; 999 wraps to 000.
    - count == limit: o_done=1 and digits are held. The FSM goes to IDLE (see Optional Feature).
  - First tick after START from IDLE occurs pCOUNT cycles after acceptance.
- Limit semantics: the limit value is visible for one full tick period before o_done fires.
  - A limit nibble >9 never matches, so the counter free-runs.
- Simultaneous events:
  - A command accepted on a prescaler-wrap cycle takes priority.
  - STOP or CLEAR suppresses that tick, o_tick and o_done.
- Reset mid-LOAD: abort to IDLE with all reset values.

Optional Feature:
- Macro: GREY_SEQ_AUTORELOAD_EN.
- Defined: on terminal match, o_done pulses, digits are reloaded from the preset register in the same edge, and the state stays RUN.
- Undefined: on terminal match, digits hold and the state goes to IDLE.

Decomposition:
- Package grey_seq_pkg:
  - State enum.
  - Command codes.
  - Johnson digit constants DIG0..DIG9.
  - bcd_to_johnson and johnson_to_bcd functions.
- One sub-module: grey_seq_digit.
  - Holds one 5-bit Johnson register with inc, load and clear.
  - Has carry-in and carry-out (carry-out = digit is 9 && inc).
  - Instantiated three times.

Test Plan:
- Reset, then START with pCOUNT=4 and limit=FFF -> first o_tick at cycle 4; units digit steps through 00001, 00011, … on each tick; 9->0 carries into tens.
- LOAD 0x998 in IDLE, then START -> ready low for 3 cycles; digits = 998; ticks give 999, then 000 with all three digits wrapping on the same edge.
- Limit=0x005 from 000 -> o_done on the 6th tick; digits stay 11111/00000/00000; without the macro state=IDLE; with GREY_SEQ_AUTORELOAD_EN digits reload the preset and state=RUN.
- RUN with prescaler=2, STOP, wait 10 cycles, START -> next o_tick occurs 1 cycle later (pCOUNT=4); digits unchanged during PAUSE.
- LOAD while RUN -> o_err pulse, digits unchanged; LOAD with nibble 0xC -> digit loaded as 9 (10000).
- Deassert i_rst_n during the 2nd LOAD cycle -> all outputs zero immediately, state=IDLE, ready=1 after release.
